// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer sharing one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW = 3,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0_Valid,
  output logic             Req0_Ready,
  input  logic [WIDTH-1:0] Req0_Operand1,
  input  logic [WIDTH-1:0] Req0_Operand2,
  input  logic [OPW-1:0]   Req0_Opcode,
  input  logic             Req0_Shift,
  input  logic             Req1_Valid,
  output logic             Req1_Ready,
  input  logic [WIDTH-1:0] Req1_Operand1,
  input  logic [WIDTH-1:0] Req1_Operand2,
  input  logic [OPW-1:0]   Req1_Opcode,
  input  logic             Req1_Shift,
  output logic             Rsp0_Valid,
  input  logic             Rsp0_Ready,
  output logic [WIDTH-1:0] Rsp0_Result,
  output logic             Rsp0_Zero,
  output logic             Rsp1_Valid,
  input  logic             Rsp1_Ready,
  output logic [WIDTH-1:0] Rsp1_Result,
  output logic             Rsp1_Zero,
  output logic [WIDTH-1:0] Operand1,
  output logic [WIDTH-1:0] Operand2,
  output logic [OPW-1:0]   Alu_Opcode,
  output logic             Shift,
  input  logic [WIDTH-1:0] Alu_Result,
  input  logic             Alu_Zero,
  output logic             Busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [OPW-1:0]   opc_q, opc_d;
  logic             shift_q, shift_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             any_req;
  logic             grant;
  logic             idle;
  assign idle = state_q == IDLE;
  assign any_req = Req0_Valid | Req1_Valid;
  assign grant = (Req0_Valid & Req1_Valid) ? ~last_q : Req1_Valid;
  assign Req0_Ready = idle & any_req & ~grant;
  assign Req1_Ready = idle & any_req & grant;
  assign Rsp0_Valid = state_q == RESP && !owner_q;
  assign Rsp1_Valid = state_q == RESP && owner_q;
  assign Rsp0_Result = res_q;
  assign Rsp1_Result = res_q;
  assign Rsp0_Zero = zero_q;
  assign Rsp1_Zero = zero_q;
  assign Operand1 = op1_q;
  assign Operand2 = op2_q;
  assign Alu_Opcode = opc_q;
  assign Shift = shift_q;
  assign Busy = !idle;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    owner_d = owner_q;
    last_d = last_q;
    op1_d = op1_q;
    op2_d = op2_q;
    opc_d = opc_q;
    shift_d = shift_q;
    res_d = res_q;
    zero_d = zero_q;
    if (idle && any_req) begin
      state_d = EXEC;
      owner_d = grant;
      last_d = grant;
      cnt_d = 4'(EXEC_CYCLES - 1);
      op1_d = grant ? Req1_Operand1 : Req0_Operand1;
      op2_d = grant ? Req1_Operand2 : Req0_Operand2;
      opc_d = grant ? Req1_Opcode : Req0_Opcode;
      shift_d = grant ? Req1_Shift : Req0_Shift;
    end else if (state_q == EXEC) begin
      cnt_d = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      state_d = cnt_q == 4'd0 ? RESP : EXEC;
      res_d = cnt_q == 4'd0 ? Alu_Result : res_q;
      zero_d = cnt_q == 4'd0 ? Alu_Zero : zero_q;
    end else if (state_q == RESP && (owner_q ? Rsp1_Ready : Rsp0_Ready)) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      op1_q <= '0;
      op2_q <= '0;
      opc_q <= '0;
      shift_q <= 1'b0;
      res_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      owner_q <= owner_d;
      last_q <= last_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      opc_q <= opc_d;
      shift_q <= shift_d;
      res_q <= res_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed self-checking bench with ALU stubs for EXEC_CYCLES 1 and 4
module tb_alu_share_arbiter;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic a_v0 = 1'b0, a_v1 = 1'b0, b_v0 = 1'b0;
  logic [15:0] op1 = '0, op2 = '0;
  logic [2:0] opc = '0;
  logic sh = 1'b0;
  logic r0 = 1'b1, r1 = 1'b1;
  logic a_rdy0, a_rdy1, a_rv0, a_rv1, a_z0, a_z1, a_sh, a_alu_z, a_busy;
  logic [15:0] a_res0, a_res1, a_op1, a_op2, a_alu_res;
  logic [2:0] a_opc;
  logic b_rdy0, b_rdy1, b_rv0, b_rv1, b_z0, b_z1, b_sh, b_alu_z, b_busy;
  logic [15:0] b_res0, b_res1, b_op1, b_op2, b_alu_res;
  logic [2:0] b_opc;
  int tests = 0;
  int fails = 0;
  always #5 Clk = ~Clk;
  function automatic logic [15:0] alu(input logic [15:0] x, input logic [15:0] y, input logic [2:0] o, input logic s);
    logic [15:0] r;
    r = o == 3'd0 ? x + y : o == 3'd1 ? x - y : o == 3'd2 ? x & y : x | y;
    return s ? r << 1 : r;
  endfunction
  always_comb begin
    a_alu_res = alu(a_op1, a_op2, a_opc, a_sh);
    a_alu_z = a_alu_res == 16'd0;
    b_alu_res = alu(b_op1, b_op2, b_opc, b_sh);
    b_alu_z = b_alu_res == 16'd0;
  end
  alu_share_arbiter #(.WIDTH(16), .OPW(3), .EXEC_CYCLES(1)) dut_a (
    .Clk(Clk), .Reset(Reset),
    .Req0_Valid(a_v0), .Req0_Ready(a_rdy0), .Req0_Operand1(op1), .Req0_Operand2(op2), .Req0_Opcode(opc), .Req0_Shift(sh),
    .Req1_Valid(a_v1), .Req1_Ready(a_rdy1), .Req1_Operand1(op1), .Req1_Operand2(op2), .Req1_Opcode(opc), .Req1_Shift(sh),
    .Rsp0_Valid(a_rv0), .Rsp0_Ready(r0), .Rsp0_Result(a_res0), .Rsp0_Zero(a_z0),
    .Rsp1_Valid(a_rv1), .Rsp1_Ready(r1), .Rsp1_Result(a_res1), .Rsp1_Zero(a_z1),
    .Operand1(a_op1), .Operand2(a_op2), .Alu_Opcode(a_opc), .Shift(a_sh),
    .Alu_Result(a_alu_res), .Alu_Zero(a_alu_z), .Busy(a_busy)
  );
  alu_share_arbiter #(.WIDTH(16), .OPW(3), .EXEC_CYCLES(4)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .Req0_Valid(b_v0), .Req0_Ready(b_rdy0), .Req0_Operand1(op1), .Req0_Operand2(op2), .Req0_Opcode(opc), .Req0_Shift(sh),
    .Req1_Valid(1'b0), .Req1_Ready(b_rdy1), .Req1_Operand1(op1), .Req1_Operand2(op2), .Req1_Opcode(opc), .Req1_Shift(sh),
    .Rsp0_Valid(b_rv0), .Rsp0_Ready(r0), .Rsp0_Result(b_res0), .Rsp0_Zero(b_z0),
    .Rsp1_Valid(b_rv1), .Rsp1_Ready(r1), .Rsp1_Result(b_res1), .Rsp1_Zero(b_z1),
    .Operand1(b_op1), .Operand2(b_op2), .Alu_Opcode(b_opc), .Shift(b_sh),
    .Alu_Result(b_alu_res), .Alu_Zero(b_alu_z), .Busy(b_busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #2;
  endtask
  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    #1;
  endtask
  initial begin
    do_reset();
    chk("rst_busy", a_busy, 0);
    chk("rst_rdy", {a_rdy0, a_rdy1}, 0);
    chk("rst_rspv", {a_rv0, a_rv1}, 0);
    chk("rst_op1", a_op1, 0);
    chk("rst_res", a_res0, 0);
    // single add
    a_v0 = 1; op1 = 16'h4; op2 = 16'h4; opc = 3'd0; sh = 0;
    #1;
    chk("add_rdy", {a_rdy0, a_rdy1}, 2'b10);
    step();
    a_v0 = 0;
    #1;
    chk("add_busy", a_busy, 1);
    chk("add_op1", a_op1, 16'h4);
    chk("add_rv_early", a_rv0, 0);
    step();
    chk("add_rv", {a_rv0, a_rv1}, 2'b10);
    chk("add_res", a_res0, 16'h8);
    chk("add_zero", a_z0, 0);
    step();
    chk("add_idle", a_busy, 0);
    // zero flag via requester 1
    a_v1 = 1; opc = 3'd1;
    #1;
    chk("sub_rdy", {a_rdy0, a_rdy1}, 2'b01);
    step();
    a_v1 = 0;
    step();
    chk("sub_rv", {a_rv0, a_rv1}, 2'b01);
    chk("sub_res", a_res1, 16'h0);
    chk("sub_zero", a_z1, 1);
    chk("sub_shift", a_sh, 0);
    step();
    // tie fairness from reset
    do_reset();
    a_v0 = 1; a_v1 = 1; opc = 3'd0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tie_grant%0d", k), {a_rdy0, a_rdy1}, k % 2 == 0 ? 2'b10 : 2'b01);
      step();
      chk($sformatf("tie_hold%0d", k), {a_rdy0, a_rdy1}, 2'b00);
      step();
      chk($sformatf("tie_rv%0d", k), {a_rv0, a_rv1}, k % 2 == 0 ? 2'b10 : 2'b01);
      step();
    end
    a_v0 = 0; a_v1 = 0;
    do_reset();
    // response stall
    a_v0 = 1; r0 = 0; op1 = 16'h10; op2 = 16'h3; opc = 3'd1;
    step();
    a_v0 = 0; a_v1 = 1;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_rv%0d", k), a_rv0, 1);
      chk($sformatf("stall_res%0d", k), a_res0, 16'hD);
      chk($sformatf("stall_busy%0d", k), a_busy, 1);
      chk($sformatf("stall_rdy1_%0d", k), a_rdy1, 0);
      step();
    end
    r0 = 1;
    step();
    chk("stall_idle", a_busy, 0);
    chk("stall_rdy1", a_rdy1, 1);
    a_v1 = 0;
    do_reset();
    // EXEC_CYCLES = 4
    b_v0 = 1; op1 = 16'h4; op2 = 16'h2; opc = 3'd3; sh = 1;
    #1;
    chk("e4_rdy", b_rdy0, 1);
    step();
    b_v0 = 0; op1 = 16'hFFFF; op2 = 16'h0; opc = 3'd0; sh = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("e4_op%0d", k), {b_op1, b_op2, b_opc, b_sh}, {16'h4, 16'h2, 3'd3, 1'b1});
      chk($sformatf("e4_rv%0d", k), b_rv0, 0);
      step();
    end
    chk("e4_rv", b_rv0, 1);
    chk("e4_res", b_res0, 16'hC);
    step();
    chk("e4_idle", b_busy, 0);
    // reset during EXEC
    a_v0 = 1; op1 = 16'h4; op2 = 16'h4; opc = 3'd0;
    step();
    a_v0 = 0;
    chk("rx_busy", a_busy, 1);
    Reset = 1;
    step();
    Reset = 0;
    #1;
    chk("rx_outs", {a_op1, a_op2, a_opc, a_sh, a_res0, a_z0, a_busy}, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rx_norsp%0d", k), {a_rv0, a_rv1}, 0);
      step();
    end
    a_v0 = 1; a_v1 = 1;
    #1;
    chk("rx_tie", {a_rdy0, a_rdy1}, 2'b10);
    a_v0 = 0; a_v1 = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
